// File: rtl/arc4_pkg.sv
// Shared types and constants for the arc4 key-search controller.
package arc4_pkg;

  localparam int KEY_W = 24;

  localparam logic [7:0] ASCII_LO = 8'h20;
  localparam logic [7:0] ASCII_HI = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_EVAL      = 3'd4,
    S_DONE      = 3'd5
  } search_state_t;

endpackage

// File: rtl/pt_checker.sv
// Sticky "non-printable byte seen" flag over the snooped arc4 plaintext writes.
module pt_checker
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  input  logic       pt_wren,
  output logic       bad
);

  logic bad_q, bad_d;
  logic hit;

  // Address 0 carries the message length, so it is never range-checked.
  always_comb begin
    hit = en && pt_wren && (pt_addr != 8'd0) &&
          ((pt_wrdata < ASCII_LO) || (pt_wrdata > ASCII_HI));
  end

  always_comb begin
    bad_d = bad_q;
    if (clr)      bad_d = 1'b0;
    else if (hit) bad_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bad_q <= 1'b0;
    else        bad_q <= bad_d;
  end

  assign bad = bad_q;

endmodule

// File: rtl/arc4_key_search.sv
// Brute-force key search: runs one arc4 decryption per candidate and accepts the first printable result.
module arc4_key_search
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'hFFFFFF,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  output logic [KEY_W-1:0] arc4_key,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata,
  input  logic             pt_wren
);

  search_state_t    state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;

  logic             chk_clr;
  logic             chk_en;
  logic             bad;
  logic [KEY_W:0]   next_sum;
  logic             exhausted;

  pt_checker u_pt_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (chk_en),
    .clr       (chk_clr),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .bad       (bad)
  );

  // 25-bit sum so a step past 24'hFFFFFF ends the search instead of wrapping.
  always_comb begin
    next_sum  = {1'b0, cand_q} + {1'b0, KEY_STEP};
    exhausted = (cand_q == KEY_LAST) || (next_sum > {1'b0, KEY_LAST});
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    chk_clr     = 1'b0;
    arc4_en     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (en) begin
          cand_d      = KEY_FIRST;
          key_valid_d = 1'b0;
          chk_clr     = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (arc4_rdy) begin
          arc4_en = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!arc4_rdy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (arc4_rdy) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (!bad) begin
          key_d       = cand_q;
          key_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (exhausted) begin
          key_d       = cand_q;
          key_valid_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          cand_d  = next_sum[KEY_W-1:0];
          chk_clr = 1'b1;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    chk_en = (state_q == S_WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= KEY_FIRST;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign rdy       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign arc4_key  = cand_q;

endmodule

// File: tb/tb_arc4_key_search.sv
// Directed bench: three searcher instances with different key ranges, each driving a small arc4 model.
module tb_arc4_key_search;

  localparam int N = 3;
  localparam int MODE_KEY3 = 0;
  localparam int MODE_NONE = 1;
  localparam int MODE_BYTE = 2;

  logic        clk;
  logic        rst_n;
  logic        en        [N];
  logic        rdy       [N];
  logic        key_valid [N];
  logic [23:0] key       [N];
  logic        arc4_en   [N];
  logic        arc4_rdy  [N];
  logic [23:0] arc4_key  [N];
  logic [7:0]  pt_addr   [N];
  logic [7:0]  pt_wrdata [N];
  logic        pt_wren   [N];
  logic        hold      [N];

  logic        m_busy [N];
  int          m_k    [N];
  logic        m_rdy  [N];
  logic [23:0] m_key  [N];
  int          pulses [N];

  int          mode;
  logic [7:0]  test_byte;
  logic [7:0]  addr0_val;

  int n_total;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic [23:0] KF = (g == 2) ? 24'hFFFFFE : 24'h000000;
    localparam logic [23:0] KL = (g == 1) ? 24'h00000F : 24'hFFFFFF;
    localparam logic [23:0] KS = (g == 2) ? 24'd4 : 24'd1;
    assign arc4_rdy[g] = m_rdy[g] & ~hold[g];
    arc4_key_search #(.KEY_FIRST(KF), .KEY_LAST(KL), .KEY_STEP(KS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[g]),
      .rdy       (rdy[g]),
      .key_valid (key_valid[g]),
      .key       (key[g]),
      .arc4_en   (arc4_en[g]),
      .arc4_rdy  (arc4_rdy[g]),
      .arc4_key  (arc4_key[g]),
      .pt_addr   (pt_addr[g]),
      .pt_wrdata (pt_wrdata[g]),
      .pt_wren   (pt_wren[g])
    );
  end

  function automatic logic [7:0] model_byte(input logic [23:0] kk, input int a);
    if (a == 0) return addr0_val;
    case (mode)
      MODE_KEY3: return (kk == 24'h3 || a != 5) ? 8'h41 : 8'h01;
      MODE_NONE: return (a == 5) ? 8'hFF : 8'h41;
      default:   return (a == 5) ? test_byte : 8'h41;
    endcase
  endfunction

  // arc4 model: rdy low for 20 cycles after a start pulse, writes addr 0..9 in the middle.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (arc4_en[i] === 1'b1) pulses[i] <= pulses[i] + 1;
      if (!rst_n) begin
        m_busy[i]    <= 1'b0;
        m_k[i]       <= 0;
        m_rdy[i]     <= 1'b1;
        pt_wren[i]   <= 1'b0;
        pt_addr[i]   <= 8'd0;
        pt_wrdata[i] <= 8'd0;
      end else if (!m_busy[i]) begin
        pt_wren[i] <= 1'b0;
        if (arc4_en[i] === 1'b1) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 0;
          m_rdy[i]  <= 1'b0;
          m_key[i]  <= arc4_key[i];
        end
      end else begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] >= 5 && m_k[i] <= 14) begin
          pt_wren[i]   <= 1'b1;
          pt_addr[i]   <= 8'(m_k[i] - 5);
          pt_wrdata[i] <= model_byte(m_key[i], m_k[i] - 5);
        end else begin
          pt_wren[i] <= 1'b0;
        end
        if (m_k[i] == 19) begin
          m_busy[i] <= 1'b0;
          m_rdy[i]  <= 1'b1;
        end
      end
    end
  end

  task automatic pulse_en(input int i);
    @(negedge clk) en[i] = 1'b1;
    @(negedge clk) en[i] = 1'b0;
  endtask

  task automatic wait_rdy(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rdy[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [23:0] kf [N];
    kf[0] = 24'h000000; kf[1] = 24'h000000; kf[2] = 24'hFFFFFE;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (rdy[i] !== 1'b1 || key_valid[i] !== 1'b0 || arc4_en[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ctl[%0d]: rdy=%b kv=%b en=%b want 1 0 0", i, rdy[i], key_valid[i], arc4_en[i]);
      end
      n_total++;
      if (key[i] !== 24'h0 || arc4_key[i] !== kf[i]) begin
        n_bad++;
        $display("FAIL reset_key[%0d]: key=%h arc4_key=%h want 000000 %h", i, key[i], arc4_key[i], kf[i]);
      end
    end
  endtask

  task automatic test_key_search;
    bit ok;
    int p0;
    mode = MODE_KEY3;
    p0 = pulses[0];
    pulse_en(0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (arc4_rdy[0] === 1'b0) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL key3_busy: got timeout want arc4 busy"); end
    repeat (5) @(negedge clk);
    n_total++;
    if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL key3_busy_rdy: got %b want 0", rdy[0]); end
    pulse_en(0);
    wait_rdy(0, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL key3_done: got timeout want rdy"); end
    n_total++;
    if (key[0] !== 24'h3 || key_valid[0] !== 1'b1) begin
      n_bad++; $display("FAIL key3_result: key=%h kv=%b want 000003 1", key[0], key_valid[0]);
    end
    n_total++;
    if (pulses[0] - p0 !== 4) begin n_bad++; $display("FAIL key3_pulses: got %0d want 4", pulses[0] - p0); end
    n_total++;
    if (arc4_key[0] !== 24'h3) begin n_bad++; $display("FAIL key3_arc4_key: got %h want 000003", arc4_key[0]); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int p0;
    mode = MODE_KEY3;
    p0 = pulses[0];
    pulse_en(0);
    n_total++;
    if (rdy[0] !== 1'b0 || key_valid[0] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_restart: rdy=%b kv=%b want 0 0", rdy[0], key_valid[0]);
    end
    wait_rdy(0, ok);
    n_total++;
    if (!ok || key[0] !== 24'h3 || key_valid[0] !== 1'b1 || pulses[0] - p0 !== 4) begin
      n_bad++;
      $display("FAIL b2b_result: ok=%b key=%h kv=%b pulses=%0d want 1 000003 1 4", ok, key[0], key_valid[0], pulses[0] - p0);
    end
  endtask

  task automatic test_exhaust;
    bit ok;
    int p0;
    mode = MODE_NONE;
    p0 = pulses[1];
    pulse_en(1);
    wait_rdy(1, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL exhaust_done: got timeout want rdy"); end
    n_total++;
    if (key[1] !== 24'h00000F || key_valid[1] !== 1'b0) begin
      n_bad++; $display("FAIL exhaust_result: key=%h kv=%b want 00000f 0", key[1], key_valid[1]);
    end
    n_total++;
    if (pulses[1] - p0 !== 16) begin n_bad++; $display("FAIL exhaust_pulses: got %0d want 16", pulses[1] - p0); end
  endtask

  task automatic test_byte_bounds;
    logic [7:0] bytes [5];
    logic [7:0] a0    [5];
    bit         acc   [5];
    bit ok;
    int p0;
    bytes[0] = 8'h20; a0[0] = 8'h09; acc[0] = 1'b1;
    bytes[1] = 8'h7E; a0[1] = 8'h09; acc[1] = 1'b1;
    bytes[2] = 8'h1F; a0[2] = 8'h09; acc[2] = 1'b0;
    bytes[3] = 8'h7F; a0[3] = 8'h09; acc[3] = 1'b0;
    bytes[4] = 8'h41; a0[4] = 8'h00; acc[4] = 1'b1;
    mode = MODE_BYTE;
    for (int t = 0; t < 5; t++) begin
      test_byte = bytes[t];
      addr0_val = a0[t];
      p0 = pulses[1];
      pulse_en(1);
      wait_rdy(1, ok);
      n_total++;
      if (acc[t]) begin
        if (!ok || key[1] !== 24'h0 || key_valid[1] !== 1'b1 || pulses[1] - p0 !== 1) begin
          n_bad++;
          $display("FAIL byte_%h_a0_%h: ok=%b key=%h kv=%b pulses=%0d want 1 000000 1 1",
                   bytes[t], a0[t], ok, key[1], key_valid[1], pulses[1] - p0);
        end
      end else begin
        if (!ok || key[1] !== 24'hF || key_valid[1] !== 1'b0 || pulses[1] - p0 !== 16) begin
          n_bad++;
          $display("FAIL byte_%h_a0_%h: ok=%b key=%h kv=%b pulses=%0d want 1 00000f 0 16",
                   bytes[t], a0[t], ok, key[1], key_valid[1], pulses[1] - p0);
        end
      end
    end
    addr0_val = 8'h09;
  endtask

  task automatic test_no_wrap;
    bit ok;
    int p0;
    mode = MODE_NONE;
    p0 = pulses[2];
    hold[2] = 1'b1;
    pulse_en(2);
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (arc4_en[2] !== 1'b0) begin n_bad++; $display("FAIL hold_en_low[%0d]: got %b want 0", c, arc4_en[2]); end
      @(negedge clk);
    end
    hold[2] = 1'b0;
    #1;
    n_total++;
    if (arc4_en[2] !== 1'b1) begin n_bad++; $display("FAIL hold_en_release: got %b want 1", arc4_en[2]); end
    wait_rdy(2, ok);
    n_total++;
    if (!ok || key[2] !== 24'hFFFFFE || key_valid[2] !== 1'b0) begin
      n_bad++; $display("FAIL nowrap_result: ok=%b key=%h kv=%b want 1 fffffe 0", ok, key[2], key_valid[2]);
    end
    n_total++;
    if (pulses[2] - p0 !== 1 || arc4_key[2] !== 24'hFFFFFE) begin
      n_bad++; $display("FAIL nowrap_pulses: pulses=%0d arc4_key=%h want 1 fffffe", pulses[2] - p0, arc4_key[2]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    mode = MODE_NONE;
    pulse_en(0);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (arc4_key[0] == 24'h2 && arc4_rdy[0] === 1'b0 && m_k[0] == 8) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok || rdy[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_setup: ok=%b rdy=%b want 1 0", ok, rdy[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_total++;
    if (rdy[0] !== 1'b1 || key_valid[0] !== 1'b0 || key[0] !== 24'h0 || arc4_key[0] !== 24'h0 || arc4_en[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state: rdy=%b kv=%b key=%h arc4_key=%h en=%b want 1 0 000000 000000 0",
               rdy[0], key_valid[0], key[0], arc4_key[0], arc4_en[0]);
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    mode      = MODE_KEY3;
    test_byte = 8'h41;
    addr0_val = 8'h09;
    for (int i = 0; i < N; i++) begin
      en[i]     = 1'b0;
      hold[i]   = 1'b0;
      pulses[i] = 0;
      m_key[i]  = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_key_search;
    test_back_to_back;
    test_exhaust;
    test_byte_bounds;
    test_no_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
